// File: rtl/cap_touch_scanner_if.sv
// Purpose : processor-side MMIO bundle for the capacitive pad scanner.
// Latency : none; plain wires grouped for port hygiene.
// Backpressure: none; status is level/pulse, clears are write-one masks.
// Ports   : enable, clear_hits, rd_sel (processor -> scanner);
//           pad_state, press_event, hit_latched, scan_done, rd_count (scanner -> processor).
interface cap_touch_scanner_if #(
   parameter int NUM_PADS = 9,
   parameter int CNT_W    = 10
);
   logic                enable;
   logic [NUM_PADS-1:0] clear_hits;
   logic [4:0]          rd_sel;
   logic [NUM_PADS-1:0] pad_state;
   logic [NUM_PADS-1:0] press_event;
   logic [NUM_PADS-1:0] hit_latched;
   logic                scan_done;
   logic [CNT_W-1:0]    rd_count;

   modport master (
      output enable, clear_hits, rd_sel,
      input  pad_state, press_event, hit_latched, scan_done, rd_count
   );

   modport slave (
      input  enable, clear_hits, rd_sel,
      output pad_state, press_event, hit_latched, scan_done, rd_count
   );
endinterface

// File: rtl/cap_touch_scanner.sv
// Purpose : N-pad capacitive scanner; charge all pads, time each discharge, threshold + debounce.
// Latency : one full scan (CHARGE_CYCLES + measure + 1); pad inputs see a 2-flop synchroniser.
// Backpressure: none; enable low lets the current scan finish, then the FSM idles.
// Ports   : clock, reset (sync, active-high), sensors_in (raw pads), sensors_out (charge drive),
//           mmio (slave side of cap_touch_scanner_if: status, hit flags, count readback).
module cap_touch_scanner #(
   parameter int NUM_PADS      = 9,
   parameter int CNT_W         = 10,
   parameter int CHARGE_CYCLES = 64,
   parameter int THRESH        = 100,
   parameter int DEBOUNCE      = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_PADS-1:0] sensors_in,
   output logic                sensors_out,
   cap_touch_scanner_if.slave  mmio
);
   localparam int CHG_W = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT = '1;

   typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_MEASURE, S_EVAL} state_t;
   state_t state, next_state;

   logic [NUM_PADS-1:0] sync1, sync2;
   logic [CHG_W-1:0]    chg_cnt;
   logic [CNT_W-1:0]    meas_cnt;
   logic [NUM_PADS-1:0] captured;
   logic [CNT_W-1:0]    work_cnt [NUM_PADS];   // counts of the scan in progress
   logic [CNT_W-1:0]    count    [NUM_PADS];   // published counts, updated in EVALUATE
   logic [DEBOUNCE-1:0] hist     [NUM_PADS];
   logic [DEBOUNCE-1:0] hist_nxt [NUM_PADS];
   logic [NUM_PADS-1:0] sample;
   logic [NUM_PADS-1:0] cap_now;
   logic                all_cap;
   logic [NUM_PADS-1:0] pad_state_q, press_q, hit_q;
   logic                scan_done_c;
   logic [CNT_W-1:0]    rd_count_c;

   // A pad is captured on the first measure cycle its synced input reads low.
   assign cap_now = ~captured & ~sync2;
   assign all_cap = &(captured | cap_now);

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      sensors_out = 1'b0;
      scan_done_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (mmio.enable) next_state = S_CHARGE;
         end
         S_CHARGE: begin
            sensors_out = 1'b1;
            if (chg_cnt == CHG_W'(CHARGE_CYCLES - 1)) next_state = S_MEASURE;
         end
         S_MEASURE: begin
            if (all_cap || meas_cnt == TIMEOUT) next_state = S_EVAL;
         end
         S_EVAL: begin
            scan_done_c = 1'b1;
            next_state  = mmio.enable ? S_CHARGE : S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // New history includes this scan's sample; state flips only on a unanimous history.
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         sample[i]   = work_cnt[i] > CNT_W'(THRESH);
         hist_nxt[i] = (hist[i] << 1) | DEBOUNCE'(sample[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1       <= '0;
         sync2       <= '0;
         chg_cnt     <= '0;
         meas_cnt    <= '0;
         captured    <= '0;
         pad_state_q <= '0;
         press_q     <= '0;
         hit_q       <= '0;
         for (int i = 0; i < NUM_PADS; i++) begin
            work_cnt[i] <= '0;
            count[i]    <= '0;
            hist[i]     <= '0;
         end
      end else begin
         sync1   <= sensors_in;
         sync2   <= sync1;
         chg_cnt <= (state == S_CHARGE) ? chg_cnt + 1'b1 : '0;
         press_q <= '0;
         // press_q feeds the set term so a same-cycle clear loses.
         hit_q   <= (hit_q & ~mmio.clear_hits) | press_q;
         case (state)
            S_CHARGE: begin
               meas_cnt <= '0;
               captured <= '0;
               // Pads never seen low keep TIMEOUT.
               for (int i = 0; i < NUM_PADS; i++) work_cnt[i] <= TIMEOUT;
            end
            S_MEASURE: begin
               if (meas_cnt != TIMEOUT) meas_cnt <= meas_cnt + 1'b1;
               for (int i = 0; i < NUM_PADS; i++) begin
                  if (cap_now[i]) begin
                     work_cnt[i] <= meas_cnt;
                     captured[i] <= 1'b1;
                  end
               end
            end
            S_EVAL: begin
               for (int i = 0; i < NUM_PADS; i++) begin
                  count[i] <= work_cnt[i];
                  hist[i]  <= hist_nxt[i];
                  if (&hist_nxt[i]) begin
                     pad_state_q[i] <= 1'b1;
                     press_q[i]     <= ~pad_state_q[i];
                  end else if (~|hist_nxt[i]) begin
                     pad_state_q[i] <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_count_c = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (mmio.rd_sel == 5'(i)) rd_count_c = count[i];
      end
   end

   assign mmio.pad_state   = pad_state_q;
   assign mmio.press_event = press_q;
   assign mmio.hit_latched = hit_q;
   assign mmio.scan_done   = scan_done_c;
   assign mmio.rd_count    = rd_count_c;
endmodule

// File: tb/tb_cap_touch_scanner.sv
// Purpose : directed self-checking bench for cap_touch_scanner with a reactive pad model.
// Latency : pads discharge a programmed number of cycles after the drive pin falls.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_cap_touch_scanner;
   localparam int NP = 9;
   localparam int HIGH_FOREVER = 1000000;

   logic          clock = 1'b0;
   logic          reset;
   logic [NP-1:0] sensors_in;
   logic          sensors_out;

   int total = 0;
   int bad   = 0;
   int dly [NP];          // -1: tied low; otherwise cycles into measure before the pad goes low
   int mcyc = 100000;

   cap_touch_scanner_if #(.NUM_PADS(NP), .CNT_W(10)) bus ();

   cap_touch_scanner #(
      .NUM_PADS(NP), .CNT_W(10), .CHARGE_CYCLES(64), .THRESH(100), .DEBOUNCE(4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sensors_in (sensors_in),
      .sensors_out(sensors_out),
      .mmio       (bus)
   );

   always #5 clock = ~clock;

   // Pad model: high while charged, falls dly[i] cycles after the drive pin drops.
   initial begin
      sensors_in = '0;
      forever begin
         @(posedge clock);
         #1;
         if (sensors_out) mcyc = -1;
         else             mcyc++;
         for (int i = 0; i < NP; i++) begin
            if (dly[i] < 0)                               sensors_in[i] = 1'b0;
            else if (!sensors_out && mcyc >= dly[i])      sensors_in[i] = 1'b0;
            else                                          sensors_in[i] = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_cnt(input int pad, input int exp);
      bus.rd_sel = 5'(pad);
      #1;
      chk($sformatf("rd_count%0d", pad), 32'(bus.rd_count), 32'(exp));
   endtask

   // Returns at the negedge inside EVALUATE.
   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clock);
      while (!bus.scan_done && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk("scan_done_seen", 32'(bus.scan_done), 1);
   endtask

   initial begin
      int n, hi, dn;
      for (int i = 0; i < NP; i++) dly[i] = -1;
      reset          = 1'b1;
      bus.enable     = 1'b1;
      bus.clear_hits = '0;
      bus.rd_sel     = '0;
      repeat (4) @(negedge clock);
      chk("rst_drive", 32'(sensors_out), 0);
      chk("rst_state", 32'(bus.pad_state), 0);
      chk("rst_press", 32'(bus.press_event), 0);
      chk("rst_hit", 32'(bus.hit_latched), 0);
      chk("rst_done", 32'(bus.scan_done), 0);
      chk("rst_count", 32'(bus.rd_count), 0);

      // Charge pulse length after reset release.
      reset = 1'b0;
      n = 0;
      while (!sensors_out && n < 10) begin @(negedge clock); n++; end
      hi = 0;
      while (sensors_out && hi < 200) begin @(negedge clock); hi++; end
      chk("charge_len", 32'(hi), 64);

      // All pads tied low.
      for (int s = 0; s < 2; s++) begin
         wait_done(3000);
         @(negedge clock);
         chk("done_pulse", 32'(bus.scan_done), 0);
         chk("low_state", 32'(bus.pad_state), 0);
         chk("low_press", 32'(bus.press_event), 0);
         for (int p = 0; p < NP; p++) chk_cnt(p, 0);
      end

      // Pad 3 falls at measure cycle 148 -> 150, touched after 4 scans.
      dly[3] = 148;
      for (int s = 1; s <= 5; s++) begin
         wait_done(3000);
         @(negedge clock);
         chk_cnt(3, 150);
         chk_cnt(0, 0);
         chk("p3_state", 32'(bus.pad_state), (s < 4) ? 0 : 32'h008);
         chk("p3_press", 32'(bus.press_event), (s == 4) ? 32'h008 : 0);
         if (s == 4) begin
            chk("hit_before", 32'(bus.hit_latched), 0);
            bus.clear_hits = 9'h008;
            @(negedge clock);
            chk("hit_set_wins", 32'(bus.hit_latched), 32'h008);
            chk("press_once", 32'(bus.press_event), 0);
            @(negedge clock);
            chk("hit_cleared", 32'(bus.hit_latched), 0);
            bus.clear_hits = '0;
         end
      end

      // Pad 5 alternates, pad 3 released (falls after 4 untouched scans).
      dly[3] = -1;
      dly[5] = 148;
      for (int s = 1; s <= 6; s++) begin
         wait_done(3000);
         @(negedge clock);
         chk_cnt(5, (s % 2 == 1) ? 150 : 0);
         chk_cnt(3, 0);
         chk("alt_state", 32'(bus.pad_state), (s < 4) ? 32'h008 : 0);
         chk("alt_press", 32'(bus.press_event), 0);
         dly[5] = (s % 2 == 1) ? -1 : 148;
      end

      // Pad 0 never discharges -> timeout count.
      dly[5] = -1;
      dly[0] = HIGH_FOREVER;
      for (int s = 1; s <= 4; s++) begin
         wait_done(3000);
         @(negedge clock);
         chk_cnt(0, 1023);
         chk("p0_state", 32'(bus.pad_state), (s < 4) ? 0 : 32'h001);
         chk("p0_press", 32'(bus.press_event), (s == 4) ? 32'h001 : 0);
      end
      chk_cnt(9, 0);
      chk_cnt(31, 0);

      // Drop enable in the middle of a long measure.
      n = 0;
      while (sensors_out !== 1'b0 && n < 200) begin @(negedge clock); n++; end
      repeat (100) @(negedge clock);
      bus.enable = 1'b0;
      wait_done(3000);
      @(negedge clock);
      chk_cnt(0, 1023);
      chk("hold_state", 32'(bus.pad_state), 32'h001);
      chk("hold_hit", 32'(bus.hit_latched), 32'h001);
      hi = 0;
      dn = 0;
      repeat (300) begin
         @(negedge clock);
         if (sensors_out)   hi++;
         if (bus.scan_done) dn++;
      end
      chk("idle_drive", 32'(hi), 0);
      chk("idle_done", 32'(dn), 0);

      // Reset in the middle of a charge.
      bus.enable = 1'b1;
      n = 0;
      while (!sensors_out && n < 10) begin @(negedge clock); n++; end
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_drive", 32'(sensors_out), 0);
      chk("mid_rst_state", 32'(bus.pad_state), 0);
      chk("mid_rst_hit", 32'(bus.hit_latched), 0);
      chk_cnt(0, 0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
